// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO write/read-side schedulers.
//   arb_state_t : arbiter FSM states (IDLE, XFER)
//   clog2_min1  : $clog2 clamped to at least 1 bit, for index/counter widths
package fifo_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_t;

   // Width helper: a single-entry range still needs one bit to hold index 0.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arb_core.sv
// rr_arb_core: combinational round-robin pick.
//   req : request vector
//   ptr : highest-priority index this round (0..NREQ-1)
//   any : at least one request present
//   idx : first requester found searching ptr, ptr+1, ... mod NREQ
module rr_arb_core
   import fifo_arb_pkg::*;
#(
   parameter  int unsigned NREQ = 4,
   localparam int unsigned IW   = clog2_min1(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic            any,
   output logic [IW-1:0]   idx
);

   localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

   logic [2*NREQ-1:0] dbl;
   logic [NREQ-1:0]   rot;
   logic [IW-1:0]     off;
   logic [IW:0]       sum;

   // Rotate so ptr sits at bit 0, priority-encode the lowest set bit, rotate back.
   always_comb begin
      dbl = {req, req} >> ptr;
      rot = dbl[NREQ-1:0];
      any = |req;
      off = '0;
      for (int j = NREQ - 1; j >= 0; j--) begin
         if (rot[IW'(j)]) off = IW'(j);
      end
      sum = {1'b0, off} + {1'b0, ptr};
      idx = (sum >= NREQ_W) ? IW'(sum - NREQ_W) : IW'(sum);
   end

endmodule

// File: rtl/fifo_wr_rr_arbiter.sv
// fifo_wr_rr_arbiter: round-robin sharing of one FIFO write port among NREQ beat streams.
//   clock, rst       : clock, async active-high reset
//   req_vld/data/last: per-requester beat stream (data for i at [i*DSIZE+:DSIZE])
//   req_rdy          : combinational accept, only to the current owner
//   fifo_almost_full : registered almost-full from the FIFO (ALMOST >= 2)
//   fifo_full        : FIFO full
//   fifo_wr_en/data  : registered FIFO write
//   grant_vld/id     : current owner
//   burst_cut        : 1-cycle pulse when MAX_BURST ends a grant before req_last
//   err_ovf          : sticky, write issued while FIFO full
module fifo_wr_rr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int unsigned NREQ      = 4,
   parameter  int unsigned DSIZE     = 8,
   parameter  int unsigned MAX_BURST = 16,
   localparam int unsigned IW        = clog2_min1(NREQ)
) (
   input  logic                  clock,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_vld,
   input  logic [NREQ*DSIZE-1:0] req_data,
   input  logic [NREQ-1:0]       req_last,
   output logic [NREQ-1:0]       req_rdy,
   input  logic                  fifo_almost_full,
   input  logic                  fifo_full,
   output logic                  fifo_wr_en,
   output logic [DSIZE-1:0]      fifo_wr_data,
   output logic                  grant_vld,
   output logic [IW-1:0]         grant_id,
   output logic                  burst_cut,
   output logic                  err_ovf
);

   localparam int unsigned CW = clog2_min1(MAX_BURST + 1);

   arb_state_t       state;
   logic [IW-1:0]    rr_ptr;
   logic [CW-1:0]    beat_cnt;
   logic             arb_any;
   logic [IW-1:0]    arb_idx;
   logic             room;
   logic             sel_vld;
   logic             sel_last;
   logic [DSIZE-1:0] sel_data;
   logic             accept;
   logic             at_limit;
   logic [IW-1:0]    next_ptr;

   rr_arb_core #(.NREQ(NREQ)) u_rr_arb_core (
      .req (req_vld),
      .ptr (rr_ptr),
      .any (arb_any),
      .idx (arb_idx)
   );

   // Almost-full is registered in the FIFO; stopping here leaves room for the one beat in flight.
   assign room = !fifo_almost_full && !fifo_full;

   // Ready only to the owner, only while transferring.
   always_comb begin
      req_rdy = '0;
      if (state == XFER) req_rdy[grant_id] = room;
   end

   // Owner's beat select.
   always_comb begin
      sel_vld  = 1'b0;
      sel_last = 1'b0;
      sel_data = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant_id == IW'(i)) begin
            sel_vld  = req_vld[i];
            sel_last = req_last[i];
            sel_data = req_data[i*DSIZE +: DSIZE];
         end
      end
   end

   assign accept   = (state == XFER) && sel_vld && room;
   assign at_limit = (beat_cnt == CW'(MAX_BURST - 1));
   assign next_ptr = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);

   // Arbitration FSM, beat counter and registered write stage.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         beat_cnt     <= '0;
         fifo_wr_en   <= 1'b0;
         fifo_wr_data <= '0;
         grant_vld    <= 1'b0;
         grant_id     <= '0;
         burst_cut    <= 1'b0;
         err_ovf      <= 1'b0;
      end else begin
         fifo_wr_en <= 1'b0;
         burst_cut  <= 1'b0;
         if (fifo_wr_en && fifo_full) err_ovf <= 1'b1;
         case (state)
            IDLE: begin
               if (arb_any) begin
                  grant_id  <= arb_idx;
                  grant_vld <= 1'b1;
                  beat_cnt  <= '0;
                  state     <= XFER;
               end
            end
            XFER: begin
               if (accept) begin
                  fifo_wr_en   <= 1'b1;
                  fifo_wr_data <= sel_data;
                  beat_cnt     <= beat_cnt + CW'(1);
                  // Packet end releases normally; hitting the burst cap releases with a cut flag.
                  if (sel_last || at_limit) begin
                     state     <= IDLE;
                     grant_vld <= 1'b0;
                     rr_ptr    <= next_ptr;
                     burst_cut <= !sel_last;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_rr_arbiter.sv
// tb_fifo_wr_rr_arbiter: directed scoreboard bench for fifo_wr_rr_arbiter.
// Requester beats carry {id, seq}; each test pushes the hand-derived write order.
`timescale 1ns/100ps
module tb_fifo_wr_rr_arbiter;

   localparam int unsigned NREQ      = 4;
   localparam int unsigned DSIZE     = 8;
   localparam int unsigned MAX_BURST = 16;
   localparam int unsigned IW        = 2;

   logic                  clock = 1'b0;
   logic                  rst   = 1'b1;
   logic [NREQ-1:0]       req_vld;
   logic [NREQ*DSIZE-1:0] req_data;
   logic [NREQ-1:0]       req_last;
   logic [NREQ-1:0]       req_rdy;
   logic                  fifo_almost_full;
   logic                  fifo_full;
   logic                  fifo_wr_en;
   logic [DSIZE-1:0]      fifo_wr_data;
   logic                  grant_vld;
   logic [IW-1:0]         grant_id;
   logic                  burst_cut;
   logic                  err_ovf;

   fifo_wr_rr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST)) dut (
      .clock            (clock),
      .rst              (rst),
      .req_vld          (req_vld),
      .req_data         (req_data),
      .req_last         (req_last),
      .req_rdy          (req_rdy),
      .fifo_almost_full (fifo_almost_full),
      .fifo_full        (fifo_full),
      .fifo_wr_en       (fifo_wr_en),
      .fifo_wr_data     (fifo_wr_data),
      .grant_vld        (grant_vld),
      .grant_id         (grant_id),
      .burst_cut        (burst_cut),
      .err_ovf          (err_ovf)
   );

   always #5 clock = ~clock;

   // beat = {gap_before[3:0], last, id[1:0], seq[5:0]}
   typedef logic [12:0] beat_t;
   typedef beat_t beat_q_t[$];
   beat_q_t     rq_q [NREQ];
   logic [7:0]  exp_q[$];
   int          gid_log[$];
   int          gcyc_log[$];

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int cut_cnt = 0;
   logic gv_d = 1'b0;

   logic [NREQ-1:0] acc;
   int  gap_left [NREQ];
   bit  fresh    [NREQ];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push_pkt(input int id, input int n, input int seq0,
                           input int gap_idx = -1, input int gap_len = 0);
      beat_t b;
      for (int k = 0; k < n; k++) begin
         b = {4'((k == gap_idx) ? gap_len : 0), (k == n - 1), 2'(id), 6'(seq0 + k)};
         rq_q[id].push_back(b);
      end
   endtask

   task automatic exp_pkt(input int id, input int n, input int seq0);
      for (int k = 0; k < n; k++) exp_q.push_back({2'(id), 6'(seq0 + k)});
   endtask

   function automatic bit rq_empty();
      int s = 0;
      for (int i = 0; i < NREQ; i++) s += rq_q[i].size();
      return (s == 0);
   endfunction

   task automatic clear_stim();
      for (int i = 0; i < NREQ; i++) begin
         rq_q[i].delete();
         fresh[i]    = 1'b1;
         gap_left[i] = 0;
      end
      acc     = '0;
      req_vld = '0;
      exp_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clock);
      #2 rst = 1'b1;
      clear_stim();
      #2 rst = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int k = 0;
      bit done = 1'b0;
      while (!done && k < 400) begin
         @(negedge clock);
         k++;
         done = (exp_q.size() == 0) && rq_empty() && !grant_vld && !fifo_wr_en;
      end
      chk(name, 32'(done), 32'd1);
      #2;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_grant_vld"}, 32'(grant_vld), 32'd0);
      chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
      chk({tag, "_wr_en"}, 32'(fifo_wr_en), 32'd0);
      chk({tag, "_wr_data"}, 32'(fifo_wr_data), 32'd0);
      chk({tag, "_burst_cut"}, 32'(burst_cut), 32'd0);
      chk({tag, "_err_ovf"}, 32'(err_ovf), 32'd0);
      chk({tag, "_req_rdy"}, 32'(req_rdy), 32'd0);
   endtask

   function automatic logic [31:0] pack_grants();
      logic [31:0] v = '0;
      for (int i = 0; i < gid_log.size(); i++) v = (v << 4) | 32'(gid_log[i]);
      return v;
   endfunction

   // Requester models: present queue heads at negedge, retire beats accepted at the posedge.
   initial begin
      acc = '0;
      req_vld = '0; req_last = '0; req_data = '0;
      for (int i = 0; i < NREQ; i++) begin fresh[i] = 1'b1; gap_left[i] = 0; end
      forever begin
         @(negedge clock);
         for (int i = 0; i < NREQ; i++) begin
            if (acc[i] && rq_q[i].size() > 0) begin
               void'(rq_q[i].pop_front());
               fresh[i] = 1'b1;
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            beat_t b;
            req_vld[i] = 1'b0;
            req_last[i] = 1'b0;
            req_data[i*DSIZE +: DSIZE] = '0;
            if (rq_q[i].size() > 0) begin
               b = rq_q[i][0];
               if (fresh[i]) begin gap_left[i] = int'(b[12:9]); fresh[i] = 1'b0; end
               if (gap_left[i] > 0) gap_left[i]--;
               else begin
                  req_vld[i] = 1'b1;
                  req_last[i] = b[8];
                  req_data[i*DSIZE +: DSIZE] = b[7:0];
               end
            end
         end
         #1;
         acc = req_vld & req_rdy & {NREQ{~rst}};
      end
   end

   // Monitor: scoreboard on every write, plus grant/burst_cut logging.
   always @(negedge clock) begin
      cyc++;
      if (rst) gv_d = 1'b0;
      else begin
         if (fifo_wr_en) begin
            if (exp_q.size() == 0) chk("sb_unexpected_write", 32'(fifo_wr_data), 32'hFFFF_FFFF);
            else chk("sb_wr_data", 32'(fifo_wr_data), 32'(exp_q.pop_front()));
         end
         if (burst_cut) cut_cnt++;
         if (grant_vld && !gv_d) begin
            gid_log.push_back(int'(grant_id));
            gcyc_log.push_back(cyc);
         end
         gv_d = grant_vld;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n, extra, bad, cut0;
   logic [9:0] pat;

   initial begin
      fifo_almost_full = 1'b0;
      fifo_full        = 1'b0;
      do_reset();
      chk_reset_outputs("rst0");

      // T1: asynchronous reset in the middle of a transfer
      push_pkt(0, 10, 0); exp_pkt(0, 10, 0);
      repeat (5) @(negedge clock);
      chk("t1_mid_xfer", 32'(grant_vld), 32'd1);
      #3 rst = 1'b1;
      #0.5;
      chk_reset_outputs("t1_async");
      #0.5 rst = 1'b0;
      clear_stim();

      // T2: single 3-beat packet from requester 0
      push_pkt(0, 3, 0); exp_pkt(0, 3, 0);
      @(negedge clock);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clock);
         case (k)
            1: begin
               chk("t2_grant_vld", 32'(grant_vld), 32'd1);
               chk("t2_grant_id", 32'(grant_id), 32'd0);
               chk("t2_wr_en_k1", 32'(fifo_wr_en), 32'd0);
            end
            2, 3: chk("t2_wr_en", 32'(fifo_wr_en), 32'd1);
            4: begin
               chk("t2_wr_en_k4", 32'(fifo_wr_en), 32'd1);
               chk("t2_release", 32'(grant_vld), 32'd0);
               chk("t2_burst_cut", 32'(burst_cut), 32'd0);
            end
            default: chk("t2_wr_en_k5", 32'(fifo_wr_en), 32'd0);
         endcase
      end
      wait_done("t2_drain");

      // T3: four requesters with 1-beat packets, rotation from pointer 0
      do_reset();
      push_pkt(0, 1, 0); push_pkt(0, 1, 1);
      push_pkt(1, 1, 0); push_pkt(2, 1, 0); push_pkt(3, 1, 0);
      exp_pkt(0, 1, 0); exp_pkt(1, 1, 0); exp_pkt(2, 1, 0); exp_pkt(3, 1, 0); exp_pkt(0, 1, 1);
      gid_log.delete(); gcyc_log.delete();
      @(negedge clock);
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         pat[k] = fifo_wr_en;
      end
      chk("t3_wr_pattern", 32'(pat), 32'(10'b1010101010));
      wait_done("t3_drain");
      chk("t3_grant_count", 32'(gid_log.size()), 32'd5);
      chk("t3_grant_order", pack_grants(), 32'h01230);
      bad = 0;
      for (int i = 1; i < gcyc_log.size(); i++) if (gcyc_log[i] - gcyc_log[i-1] != 2) bad++;
      chk("t3_grant_spacing", 32'(bad), 32'd0);

      // T4: 20-beat packet from requester 2 cut at 16 beats, requester 3 slips in
      cut0 = cut_cnt;
      gid_log.delete(); gcyc_log.delete();
      push_pkt(2, 20, 0); push_pkt(3, 1, 0);
      exp_pkt(2, 16, 0); exp_pkt(3, 1, 0); exp_pkt(2, 4, 16);
      wait_done("t4_drain");
      chk("t4_burst_cut_cycles", 32'(cut_cnt - cut0), 32'd1);
      chk("t4_grant_order", pack_grants(), 32'h232);

      // T5: almost-full for 10 cycles after 5 writes
      push_pkt(0, 12, 0); exp_pkt(0, 12, 0);
      n = 0;
      for (int k = 0; k < 100 && n < 5; k++) begin
         @(negedge clock);
         if (fifo_wr_en) n++;
      end
      chk("t5_five_writes", 32'(n), 32'd5);
      chk("t5_rdy_before", 32'(req_rdy), 32'b0001);
      fifo_almost_full = 1'b1;
      #1;
      chk("t5_rdy_same_cycle", 32'(req_rdy), 32'd0);
      extra = 0; bad = 0;
      repeat (10) begin
         @(negedge clock);
         if (fifo_wr_en) extra++;
         if (req_rdy != '0) bad++;
      end
      fifo_almost_full = 1'b0;
      chk("t5_extra_writes_le1", 32'(extra <= 1), 32'd1);
      chk("t5_rdy_held_low", 32'(bad), 32'd0);
      wait_done("t5_drain");
      chk("t5_err_ovf", 32'(err_ovf), 32'd0);

      // T6: requester 1 stalls 7 cycles mid-packet, requester 0 waits
      gid_log.delete(); gcyc_log.delete();
      push_pkt(1, 4, 0, 2, 7); push_pkt(0, 2, 0);
      exp_pkt(1, 4, 0); exp_pkt(0, 2, 0);
      n = 0;
      for (int k = 0; k < 100 && n < 2; k++) begin
         @(negedge clock);
         if (fifo_wr_en) n++;
      end
      chk("t6_two_writes", 32'(n), 32'd2);
      extra = 0; bad = 0;
      repeat (7) begin
         @(negedge clock);
         if (fifo_wr_en) extra++;
         if (!grant_vld || grant_id != 2'd1) bad++;
      end
      chk("t6_no_gap_writes", 32'(extra), 32'd0);
      chk("t6_grant_held", 32'(bad), 32'd0);
      wait_done("t6_drain");
      chk("t6_grant_order", pack_grants(), 32'h10);

      // T7: write while full sets sticky err_ovf, cleared only by reset
      chk("t7_err_ovf_clear", 32'(err_ovf), 32'd0);
      push_pkt(2, 1, 5); exp_pkt(2, 1, 5);
      n = 0;
      for (int k = 0; k < 50 && n == 0; k++) begin
         @(negedge clock);
         if (fifo_wr_en) n = 1;
      end
      chk("t7_write_seen", 32'(n), 32'd1);
      fifo_full = 1'b1;
      @(negedge clock);
      chk("t7_err_ovf_set", 32'(err_ovf), 32'd1);
      fifo_full = 1'b0;
      repeat (3) @(negedge clock);
      chk("t7_err_ovf_sticky", 32'(err_ovf), 32'd1);
      wait_done("t7_drain");
      do_reset();
      chk("t7_err_ovf_reset", 32'(err_ovf), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
